bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Sequential, parametrised BCD-to-binary converter for the calculator datapath.
- Generalises the fixed ×10/×100/×1000 digit-weight multipliers into one iterative Horner engine (acc = acc·10 + digit) for any digit count.
- Uses a valid/ready handshake on input and output.
- Sits between keypad digit capture and the binary ALU.

Parameters:
- DIGITS, 4, number of BCD digits converted per operand (≥1).
- OUT_W, 14, binary result width; must be ≥ ceil(log2(10^DIGITS)) for overflow-free results.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bcd holds an operand to convert.
- in_ready  output  1  block can accept an operand (IDLE only).
- in_bcd  input  4*DIGITS  packed BCD; digit k at [4k+3:4k]; digit DIGITS-1 is most significant.
- out_valid  output  1  out_bin/err hold a finished result.
- out_ready  input  1  consumer accepts result.
- out_bin  output  OUT_W  unsigned binary result.
- err  output  1  invalid digit / overflow flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, any time, asynchronous): state = IDLE; in_ready = 1; out_valid = 0; out_bin = 0; err = 0; accumulator, digit shift register and counter all cleared.
- Reset mid-conversion discards the operand; no partial result is ever presented.
- State IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture in_bcd into the digit shift register, clear acc, load counter = DIGITS-1, go to CONV.
- State CONV:
  - in_ready = 0.
  - Each edge: acc <= (acc<<3) + (acc<<1) + top digit.
  - The sum is computed at OUT_W+4 bits, then truncated to OUT_W (modulo 2^OUT_W).
  - After the update, the shift register shifts left by 4 bits and the counter decrements.
  - On the edge where counter = 0: write the final value to out_bin, set out_valid = 1, go to HOLD.
- Latency: out_valid is high after exactly DIGITS rising edges following the accepting edge (4 for the default).
- Throughput: one operand per DIGITS+2 cycles minimum.
- State HOLD:
  - out_valid = 1; out_bin and err are stable.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE.
  - out_bin retains its last value after the handshake.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside HOLD.
  - No combinational path from in_valid/out_ready to any output; all outputs are registered.
- Boundary conditions:
  - All-zero operand gives 0.
  - All-nines operand gives 10^DIGITS-1.
  - DIGITS = 1 gives a single CONV cycle.
  - in_valid held high continuously starts a new conversion only on the first IDLE cycle after each handshake.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - err is set in the HOLD cycle if any digit of the operand was > 9, or if any Horner step overflowed OUT_W bits (nonzero truncated high bits).
  - err clears when HOLD is left.
  - out_bin still carries the truncated arithmetic result.
- Undefined:
  - err is tied to 0.
  - Digits 10–15 are accumulated arithmetically with no detection.
  - No check logic is synthesised.

Test Plan:
- DIGITS=4, OUT_W=14; in_bcd=16'h1234, in_valid one cycle, out_ready=1 → out_valid after 4 edges, out_bin=1234 (0x04D2), err=0; in_ready high again the cycle after the handshake.
- in_bcd=16'h9999, then 16'h0000 back-to-back with in_valid held high → results 9999 (0x270F) then 0, each presented exactly once.
- in_bcd=16'h0507; out_ready held low 6 cycles after out_valid → out_bin=507 stable and out_valid high throughout; in_ready stays 0; a second in_valid in that window is ignored.
- Assert rst_n low after the second CONV edge of 16'h4321 → out_valid stays 0 and in_ready=1 immediately; a new 16'h0042 then converts to 42.
- With BCD_CHECK_EN: in_bcd=16'h12A4 → err=1 with out_valid; following 16'h0010 → err=0, out_bin=10. Without the macro: err=0 for the same stimulus.
- DIGITS=2, OUT_W=7 instance: in_bcd=8'h99 → out_bin=99 after 2 edges; DIGITS=4, OUT_W=10 with 16'h2000 under BCD_CHECK_EN → err=1, out_bin=2000 mod 1024 = 976.

Source files
------------

// File: rtl/bcd_to_bin_if.sv
// Valid/ready handshake bundle between keypad digit capture, the BCD-to-binary
// converter and the binary ALU.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_bin;
  logic                  err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, err
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Iterative Horner BCD-to-binary converter (acc = acc*10 + digit), one digit per clock.
// Optional macro BCD_CHECK_EN enables invalid-digit / overflow detection on err.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_to_bin_if.slave   bus
);
  localparam int IN_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_reg;
  logic [OUT_W-1:0]   acc_reg;
  logic [IN_W-1:0]    shift_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [OUT_W-1:0]   out_bin_reg;

  logic [3:0]         top_digit;
  logic [OUT_W+3:0]   acc_wide;
  logic [OUT_W+3:0]   sum_wide;
  logic [OUT_W-1:0]   acc_next;

  // Four spare bits keep acc*10 + 15 exact so overflow is visible before truncation.
  assign top_digit = shift_reg[IN_W-1 -: 4];
  assign acc_wide  = {4'd0, acc_reg};
  assign sum_wide  = (acc_wide << 3) + (acc_wide << 1) + {{OUT_W{1'b0}}, top_digit};
  assign acc_next  = sum_wide[OUT_W-1:0];

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_bin   = out_bin_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_bin_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            shift_reg    <= bus.in_bcd;
            acc_reg      <= '0;
            cnt_reg      <= CNT_W'(DIGITS - 1);
            in_ready_reg <= 1'b0;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          acc_reg   <= acc_next;
          shift_reg <= shift_reg << 4;
          if (cnt_reg == '0) begin
            out_bin_reg   <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_CHECK_EN
  logic [DIGITS-1:0] digit_bad;
  logic              step_ovf;
  logic              flag_reg;
  logic              err_reg;

  // Digit validity is judged once on the captured operand, not per shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
      assign digit_bad[gi] = (bus.in_bcd[4*gi+3 -: 4] > 4'd9);
    end
  endgenerate

  assign step_ovf = |sum_wide[OUT_W+3:OUT_W];
  assign bus.err  = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            flag_reg <= |digit_bad;
          end
        end
        CONV: begin
          flag_reg <= flag_reg | step_ovf;
          if (cnt_reg == '0) begin
            err_reg <= flag_reg | step_ovf;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            err_reg <= 1'b0;
          end
        end
        default: begin
          flag_reg <= 1'b0;
          err_reg  <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^sum_wide[OUT_W+3:OUT_W];
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: vector table, handshake corner sequences,
// randomized operands against a positional-sum reference model, and two small instances.
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_to_bin_if #(.DIGITS(4), .OUT_W(14)) bus  ();
  bcd_to_bin_if #(.DIGITS(2), .OUT_W(7))  bus2 ();
  bcd_to_bin_if #(.DIGITS(4), .OUT_W(10)) bus3 ();

  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bcd_to_bin_seq #(.DIGITS(2), .OUT_W(7))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(10)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] bcd;
    int unsigned bin;
    bit          err_chk;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // err only exists when the check feature is compiled in.
  function automatic bit exp_err(input bit raw);
`ifdef BCD_CHECK_EN
    return raw;
`else
    return raw & 1'b0;
`endif
  endfunction

  // Reference: plain positional sum of digit*10^k, reduced modulo 2^w.
  function automatic void model(input logic [15:0] bcd, input int w,
                                output int unsigned bin, output bit e);
    int unsigned val = 0;
    int unsigned p   = 1;
    bit          bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int unsigned d = 32'(bcd[4*k +: 4]);
      val += d * p;
      p   *= 10;
      if (d > 9) bad = 1'b1;
    end
    bin = val % (32'd1 << w);
    e   = exp_err(bad || (val >= (32'd1 << w)));
  endfunction

  task automatic do_op(input logic [15:0] bcd, input int hold, input bit poke,
                       input int unsigned exp_bin, input bit exp_e);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.in_bcd    = bcd;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bcd   = 16'($urandom);
    chk("in_ready_conv", 32'(bus.in_ready), 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 4);
    chk("out_bin", 32'(bus.out_bin), exp_bin);
    chk("err", 32'(bus.err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h0999;
      end
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_bin", 32'(bus.out_bin), exp_bin);
      chk("hold_err", 32'(bus.err), 32'(exp_e));
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 0);
    chk("post_in_ready", 32'(bus.in_ready), 1);
    chk("post_bin", 32'(bus.out_bin), exp_bin);
    chk("post_err", 32'(bus.err), 0);
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    $display("op bcd=%h expect_bin=%0d expect_err=%0b latency=%0d hold=%0d poke=%0b",
             bcd, exp_bin, exp_e, lat, hold, poke);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned mbin;
    bit          me;
    logic [15:0] rbcd;
    int          seen;
    int          first_t;
    int          second_t;
    int          t;
    int          extra;
    int unsigned got_q[$];
    int          l2;
    int          l3;
    int unsigned b2;
    int unsigned b3;
    bit          e3;
    bit          got2;
    bit          got3;

    vecs[0] = '{16'h1234, 1234, 1'b0};
    vecs[1] = '{16'h0000, 0, 1'b0};
    vecs[2] = '{16'h9999, 9999, 1'b0};
    vecs[3] = '{16'h0507, 507, 1'b0};
    vecs[4] = '{16'h0001, 1, 1'b0};
    vecs[5] = '{16'h8000, 8000, 1'b0};
    vecs[6] = '{16'h12A4, 1304, 1'b1};
    vecs[7] = '{16'h0010, 10, 1'b0};
    vecs[8] = '{16'hFFFF, 281, 1'b1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.in_bcd = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_bcd = '0; bus2.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_bcd = '0; bus3.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_bin", 32'(bus.out_bin), 0);
    chk("rst_err", 32'(bus.err), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].bcd, 0, 1'b0, vecs[i].bin, exp_err(vecs[i].err_chk));
    end

    // Back-to-back with in_valid held high: each result exactly once, DIGITS+2 apart.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = 16'h9999;
    seen = 0; first_t = 0; second_t = 0; t = 0;
    while (seen < 2 && t < 30) begin
      @(negedge clk);
      t++;
      if (t == 1) bus.in_bcd = 16'h0000;
      if (bus.out_valid === 1'b1) begin
        seen++;
        got_q.push_back(32'(bus.out_bin));
        if (seen == 1) first_t = t;
        else begin
          second_t = t;
          bus.in_valid = 1'b0;
        end
      end
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) extra++;
    end
    bus.out_ready = 1'b0;
    chk("b2b_count", 32'(seen), 2);
    chk("b2b_extra", 32'(extra), 0);
    if (seen == 2) begin
      chk("b2b_first", got_q[0], 9999);
      chk("b2b_second", got_q[1], 0);
      chk("b2b_spacing", 32'(second_t - first_t), 6);
    end
    $display("op b2b seen=%0d spacing=%0d", seen, second_t - first_t);

    // Stalled consumer with an ignored in_valid during the stall.
    do_op(16'h0507, 6, 1'b1, 507, 1'b0);

    // Asynchronous reset after the second CONV edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h4321;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_out_bin", 32'(bus.out_bin), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) extra++;
    end
    chk("mid_rst_no_result", 32'(extra), 0);
    $display("op reset mid-conversion bcd=4321 spurious_results=%0d", extra);
    do_op(16'h0042, 0, 1'b0, 42, 1'b0);

    // Randomized operands, mostly valid digits with occasional 10..15.
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0) rbcd[4*k +: 4] = 4'($urandom_range(10, 15));
        else                           rbcd[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      model(rbcd, 14, mbin, me);
      do_op(rbcd, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), mbin, me);
    end

    // Narrow instances: DIGITS=2 latency, and OUT_W=10 truncation of 2000.
    @(negedge clk);
    bus2.out_ready = 1'b1;  bus3.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;  bus2.in_bcd    = 8'h99;
    bus3.in_valid  = 1'b1;  bus3.in_bcd    = 16'h2000;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    l2 = 0; l3 = 0; b2 = 0; b3 = 0; e3 = 1'b0; got2 = 1'b0; got3 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!got2 && bus2.out_valid === 1'b1) begin
        got2 = 1'b1; l2 = i; b2 = 32'(bus2.out_bin);
      end
      if (!got3 && bus3.out_valid === 1'b1) begin
        got3 = 1'b1; l3 = i; b3 = 32'(bus3.out_bin); e3 = bus3.err;
      end
    end
    chk("d2_latency", 32'(l2), 2);
    chk("d2_bin", b2, 99);
    chk("w10_latency", 32'(l3), 4);
    chk("w10_bin", b3, 976);
    chk("w10_err", 32'(e3), 32'(exp_err(1'b1)));
    $display("op narrow d2: bin=%0d lat=%0d  w10: bin=%0d err=%0b lat=%0d", b2, l2, b3, e3, l3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
